// File: rtl/dp_pkg.sv
// Shared definitions for the multicycle datapath: opcode and ALU function
// codes, the control FSM state type and an opcode-legality helper.
package dp_pkg;

   localparam logic [3:0] OP_RTYPE = 4'd0;
   localparam logic [3:0] OP_ADDI  = 4'd1;
   localparam logic [3:0] OP_LW    = 4'd2;
   localparam logic [3:0] OP_SW    = 4'd3;
   localparam logic [3:0] OP_BEQ   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [1:0] FN_ADD = 2'd0;
   localparam logic [1:0] FN_SUB = 2'd1;
   localparam logic [1:0] FN_AND = 2'd2;
   localparam logic [1:0] FN_OR  = 2'd3;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   function automatic logic op_defined(input logic [3:0] op);
      return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT};
   endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: add/sub/and/or with zero flag and two's-complement
// overflow detection for add and sub.
module dp_alu
   import dp_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        funct,
   output logic [DATA_W-1:0] y,
   output logic              zero,
   output logic              ovf
);

   always_comb begin
      y   = a + b;
      ovf = 1'b0;
      case (funct)
         FN_ADD: ovf = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
         FN_SUB: begin
            y   = a - b;
            ovf = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
         end
         FN_AND:  y = a & b;
         default: y = a | b;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle 16-bit-instruction core: FETCH/DECODE/EXEC/MEM/WB/HALT control over
// a 4-entry register file. Define DATAPATH_OVF_TRAP_EN to halt on signed overflow.
module multicycle_datapath
   import dp_pkg::*;
#(
   parameter int          DATA_W   = 16,
   parameter int          NREG     = 4,
   parameter logic [15:0] PC_RESET = 16'd10,
   parameter int          CNT_W    = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [15:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [15:0]       pc,
   output logic              halted,
   output logic              illegal,
   output logic              retire,
   output logic [CNT_W-1:0]  retired_cnt
);

`ifdef DATAPATH_OVF_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [15:0]       pc_q, pc_d, ir_q;
   logic [DATA_W-1:0] a_q, b_q, res_q;
   logic [DATA_W-1:0] regs [NREG];
   logic [CNT_W-1:0]  cnt_q;
   logic              illegal_q;

   logic              ir_ld, op_ld, res_ld, rdata_ld, rf_we, ill_set;
   logic [DATA_W-1:0] alu_b, alu_y;
   logic [1:0]        alu_fn;
   logic              alu_zero, alu_ovf, trap;

   logic [3:0]        opcode;
   logic [1:0]        rs, rt, rd, funct, dest;
   logic [DATA_W-1:0] imm_ext;
   logic [15:0]       br_off;

   assign opcode  = ir_q[15:12];
   assign rs      = ir_q[11:10];
   assign rt      = ir_q[9:8];
   assign rd      = ir_q[7:6];
   assign funct   = ir_q[1:0];
   assign imm_ext = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
   assign br_off  = {{7{ir_q[7]}}, ir_q[7:0], 1'b0};
   assign dest    = (opcode == OP_RTYPE) ? rd : rt;

   // BEQ compares by subtraction; loads, stores and ADDI add the immediate.
   always_comb begin
      alu_b  = b_q;
      alu_fn = FN_ADD;
      if (opcode == OP_RTYPE)   alu_fn = funct;
      else if (opcode == OP_BEQ) alu_fn = FN_SUB;
      else                       alu_b  = imm_ext;
   end

   dp_alu #(.DATA_W(DATA_W)) u_alu (
      .a     (a_q),
      .b     (alu_b),
      .funct (alu_fn),
      .y     (alu_y),
      .zero  (alu_zero),
      .ovf   (alu_ovf)
   );

   assign trap = TRAP_EN && alu_ovf &&
                 (((opcode == OP_RTYPE) && (funct == FN_ADD || funct == FN_SUB)) ||
                  (opcode == OP_ADDI));

   always_ff @(posedge Clock) begin
      if (Reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = pc_q;
      retire   = 1'b0;
      ir_ld    = 1'b0;
      op_ld    = 1'b0;
      res_ld   = 1'b0;
      rdata_ld = 1'b0;
      rf_we    = 1'b0;
      ill_set  = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_ld   = 1'b1;
               pc_d    = pc_q + 16'd2;
               state_d = DECODE;
            end
         end
         DECODE: begin
            op_ld = 1'b1;
            if (!op_defined(opcode)) begin
               ill_set = 1'b1;
               state_d = HALT;
            end else if (opcode == OP_HALT) state_d = HALT;
            else                            state_d = EXEC;
         end
         EXEC: begin
            case (opcode)
               OP_RTYPE, OP_ADDI: begin
                  if (trap) state_d = HALT;
                  else begin
                     res_ld  = 1'b1;
                     state_d = WB;
                  end
               end
               OP_LW, OP_SW: begin
                  res_ld  = 1'b1;
                  state_d = MEM;
               end
               default: begin  // only BEQ reaches EXEC with any other opcode
                  retire  = 1'b1;
                  state_d = FETCH;
                  if (alu_zero) pc_d = pc_q + br_off;
               end
            endcase
         end
         MEM: begin
            mem_req  = 1'b1;
            mem_we   = (opcode == OP_SW);
            mem_addr = res_q[15:0];
            if (mem_ack) begin
               if (opcode == OP_SW) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  rdata_ld = 1'b1;
                  state_d  = WB;
               end
            end
         end
         WB: begin
            rf_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
         end
         default: ;
      endcase
      if (Reset) begin
         mem_req = 1'b0;
         retire  = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc_q      <= PC_RESET;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         // NOTE: the register file is reset explicitly because programs rely on r0-r3 starting at zero.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         pc_q <= pc_d;
         if (ir_ld) ir_q <= mem_rdata[15:0];
         if (op_ld) begin
            a_q <= regs[rs];
            b_q <= regs[rt];
         end
         if (res_ld)   res_q <= alu_y;
         if (rdata_ld) res_q <= mem_rdata;
         if (rf_we)    regs[dest] <= res_q;
         if (retire)   cnt_q <= cnt_q + CNT_W'(1);
         if (ill_set)  illegal_q <= 1'b1;
      end
   end

   assign pc          = pc_q;
   assign mem_wdata   = b_q;
   assign halted      = (state_q == HALT) && !Reset;
   assign illegal     = illegal_q;
   assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: directed program steps plus random
// instructions, each compared against an instruction-level reference model.
module tb_multicycle_datapath;

   localparam int          DW  = 16;
   localparam int          CW  = 16;
   localparam logic [15:0] PC0 = 16'd10;
`ifdef DATAPATH_OVF_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_req, mem_we, halted, illegal, retire;
   logic [15:0]   mem_addr, pc;
   logic [DW-1:0] mem_wdata;
   logic [CW-1:0] retired_cnt;

   multicycle_datapath #(.DATA_W(DW), .NREG(4), .PC_RESET(PC0), .CNT_W(CW)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .pc          (pc),
      .halted      (halted),
      .illegal     (illegal),
      .retire      (retire),
      .retired_cnt (retired_cnt)
   );

   always #5 Clock = ~Clock;

   int n_cmp = 0;
   int n_err = 0;

   // Architectural reference state
   logic [DW-1:0] m_regs [4];
   logic [15:0]   m_pc;
   logic [CW-1:0] m_cnt;
   bit            m_ill, m_halt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_pc   = PC0;
      m_cnt  = '0;
      m_ill  = 1'b0;
      m_halt = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) check($sformatf("%s_r%0d", tag, i), dut.regs[i], m_regs[i]);
   endtask

   // Executes one instruction architecturally and predicts its cycle count.
   task automatic model_step(input logic [15:0] ins, input logic [DW-1:0] ldata,
                             output int lat, output bit ret, output bit hlt, output bit is_mem,
                             output logic [15:0] addr, output bit we, output logic [DW-1:0] wdata);
      logic [3:0]    op;
      int            rs, rt, rd;
      logic [DW-1:0] a, b, res, ea;
      longint        sa, sb, sr, smax, smin, simm;
      bit            ovf;
      op   = ins[15:12];
      rs   = int'(ins[11:10]);
      rt   = int'(ins[9:8]);
      rd   = int'(ins[7:6]);
      a    = m_regs[rs];
      b    = m_regs[rt];
      simm = longint'($signed(ins[7:0]));
      smax = (longint'(1) << (DW-1)) - 1;
      smin = -(longint'(1) << (DW-1));
      m_pc = m_pc + 16'd2;
      ret = 1'b1; hlt = 1'b0; is_mem = 1'b0; addr = '0; we = 1'b0; wdata = '0; lat = 0;
      ea = a + DW'(simm);
      case (op)
         4'd0, 4'd1: begin
            sa  = longint'($signed(a));
            sb  = (op == 4'd0) ? longint'($signed(b)) : simm;
            ovf = 1'b0;
            sr  = 0;
            res = '0;
            if (op == 4'd1 || ins[1:0] == 2'd0) begin
               sr = sa + sb; res = DW'(sr); ovf = (sr > smax) || (sr < smin);
            end else if (ins[1:0] == 2'd1) begin
               sr = sa - sb; res = DW'(sr); ovf = (sr > smax) || (sr < smin);
            end else if (ins[1:0] == 2'd2) res = a & b;
            else                           res = a | b;
            lat = 4;
            if (TRAP && ovf) begin
               ret = 1'b0; hlt = 1'b1;
            end else m_regs[(op == 4'd0) ? rd : rt] = res;
         end
         4'd2: begin
            lat = 5; is_mem = 1'b1; addr = ea[15:0];
            m_regs[rt] = ldata;
         end
         4'd3: begin
            lat = 4; is_mem = 1'b1; addr = ea[15:0]; we = 1'b1; wdata = b;
         end
         4'd4: begin
            lat = 3;
            if (a == b) m_pc = 16'(int'(m_pc) + 2 * int'(simm));
         end
         4'd15: begin
            lat = 3; ret = 1'b0; hlt = 1'b1;
         end
         default: begin
            lat = 3; ret = 1'b0; hlt = 1'b1; m_ill = 1'b1;
         end
      endcase
      if (ret) m_cnt = m_cnt + CW'(1);
      if (hlt) m_halt = 1'b1;
   endtask

   // Acts as the memory for one instruction; returns when retire or halted is seen.
   task automatic run_instr(input logic [15:0] ins, input int fwait, input int mwait,
                            input logic [DW-1:0] ldata, output int lat, output bit ret_seen,
                            output bit halt_seen, output logic [15:0] faddr, output logic [15:0] maddr,
                            output bit mwe, output logic [DW-1:0] mwd, output bit stable,
                            output bit dropped);
      int          waitc;
      bit          fetch_done, in_req, prev_rd_ack;
      logic [15:0] req_addr;
      waitc = 0; fetch_done = 1'b0; in_req = 1'b0; prev_rd_ack = 1'b0; req_addr = '0;
      lat = 0; ret_seen = 1'b0; halt_seen = 1'b0; faddr = '0; maddr = '0;
      mwe = 1'b0; mwd = '0; stable = 1'b1; dropped = 1'b0;
      while (!ret_seen && !halt_seen && lat < 64) begin
         lat++;
         mem_ack   = 1'b0;
         mem_rdata = DW'($urandom);
         if (prev_rd_ack && mem_req) dropped = 1'b1;
         prev_rd_ack = 1'b0;
         if (mem_req) begin
            if (!in_req) begin
               in_req = 1'b1; waitc = 0; req_addr = mem_addr;
               if (!fetch_done) faddr = mem_addr;
            end else if (mem_addr !== req_addr) stable = 1'b0;
            if (waitc == (fetch_done ? mwait : fwait)) begin
               mem_ack = 1'b1;
               if (fetch_done) begin
                  mem_rdata = ldata;
                  maddr = mem_addr; mwe = mem_we; mwd = mem_wdata;
               end else mem_rdata = DW'({16'($urandom), ins});
               prev_rd_ack = !mem_we;
               fetch_done  = 1'b1;
               in_req      = 1'b0;
            end else waitc++;
         end
         #1;
         if (retire) ret_seen = 1'b1;
         if (halted) halt_seen = 1'b1;
         @(posedge Clock); #1;
      end
      mem_ack = 1'b0;
   endtask

   task automatic do_instr(input string tag, input logic [15:0] ins, input int fwait, input int mwait,
                           input logic [DW-1:0] ldata, output int lat);
      int            e_lat;
      bit            e_ret, e_hlt, is_mem, e_we, ret, hlt, we, stable, dropped;
      logic [15:0]   e_addr, addr, faddr, pc_before;
      logic [DW-1:0] e_wd, wd;
      pc_before = m_pc;
      model_step(ins, ldata, e_lat, e_ret, e_hlt, is_mem, e_addr, e_we, e_wd);
      e_lat += fwait + (is_mem ? mwait : 0);
      run_instr(ins, fwait, mwait, ldata, lat, ret, hlt, faddr, addr, we, wd, stable, dropped);
      check({tag, "_faddr"}, faddr, pc_before);
      check({tag, "_lat"}, lat, e_lat);
      check({tag, "_retire"}, ret, e_ret);
      check({tag, "_halted"}, hlt, e_hlt);
      check({tag, "_pc"}, pc, m_pc);
      check({tag, "_cnt"}, retired_cnt, m_cnt);
      check({tag, "_illegal"}, illegal, m_ill);
      check({tag, "_req_drop"}, dropped, 1'b0);
      check_regs(tag);
      if (is_mem) begin
         check({tag, "_maddr"}, addr, e_addr);
         check({tag, "_mwe"}, we, e_we);
         check({tag, "_stable"}, stable, 1'b1);
         if (e_we) check({tag, "_wdata"}, wd, e_wd);
      end
   endtask

   task automatic do_reset();
      Reset   = 1'b1;
      mem_ack = 1'b1;
      #1;
      check("rst_halted", halted, 1'b0);
      check("rst_req", mem_req, 1'b0);
      check("rst_retire", retire, 1'b0);
      @(posedge Clock); #1;
      check("rst_req_hold", mem_req, 1'b0);
      @(posedge Clock); #1;
      Reset   = 1'b0;
      mem_ack = 1'b0;
      #1;
      model_reset();
      check("rst_pc", pc, m_pc);
      check("rst_cnt", retired_cnt, m_cnt);
      check("rst_illegal", illegal, 1'b0);
      check("rst_fetch_req", mem_req, 1'b1);
      check("rst_fetch_addr", mem_addr, m_pc);
      check_regs("rst");
   endtask

   // HALT must be absorbing: no requests, no PC or counter movement.
   task automatic absorb(input string tag);
      for (int k = 0; k < 4; k++) begin
         mem_ack   = 1'(k % 2);
         mem_rdata = DW'($urandom);
         #1;
         check({tag, "_req"}, mem_req, 1'b0);
         check({tag, "_halted"}, halted, 1'b1);
         check({tag, "_pc"}, pc, m_pc);
         check({tag, "_cnt"}, retired_cnt, m_cnt);
         check({tag, "_retire"}, retire, 1'b0);
         @(posedge Clock); #1;
      end
      mem_ack = 1'b0;
      check_regs(tag);
   endtask

   initial begin
      int            lat;
      logic [15:0]   ins;
      int            sel;
      logic [3:0]    op;

      repeat (2) @(posedge Clock);
      #1;
      do_reset();

      // ADDI r1, r0, 5
      do_instr("addi", 16'h1105, 0, 0, '0, lat);
      check("addi_lat4", lat, 4);
      check("addi_pc12", pc, 16'd12);
      check("addi_r1", dut.regs[1], 16'd5);

      // LW r2, 4(r1) with three wait cycles on the data access
      do_instr("lw_wait", 16'h2604, 0, 3, DW'($urandom), lat);
      check("lw_lat8", lat, 8);

      // Walk to pc 20 with r2 == r1, then taken / not-taken BEQ r1, r2, -2
      do_instr("mov_r2", 16'h1600, 1, 0, '0, lat);
      do_instr("inc_r3a", 16'h1F01, 0, 0, '0, lat);
      do_instr("inc_r3b", 16'h1F01, 2, 0, '0, lat);
      check("pre_beq_pc", pc, 16'd20);
      do_instr("beq_t", 16'h46FE, 0, 0, '0, lat);
      check("beq_t_pc18", pc, 16'd18);
      check("beq_t_lat3", lat, 3);
      do_instr("inc_r2", 16'h1A01, 0, 0, '0, lat);
      do_instr("beq_nt", 16'h46FE, 0, 0, '0, lat);
      check("beq_nt_pc22", pc, 16'd22);

      // 0x7FFF + 1 through an R-type add into r3
      do_instr("ovf_lw", 16'h2100, 0, 1, 16'h7FFF, lat);
      do_instr("ovf_addi", 16'h1201, 0, 0, '0, lat);
      do_instr("ovf_add", 16'h06C0, 0, 0, '0, lat);
`ifdef DATAPATH_OVF_TRAP_EN
      check("ovf_trap_halted", halted, 1'b1);
      check("ovf_trap_rd", dut.regs[3], 16'd2);
`else
      check("ovf_wrap_rd", dut.regs[3], 16'h8000);
`endif
      if (m_halt) do_reset();

      // SW r3, 0x10(r0)
      do_instr("sw", 16'h3310, 0, 2, '0, lat);

      for (int k = 0; k < 120; k++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: op = 4'd0;
            3, 4:    op = 4'd1;
            5, 6:    op = 4'd2;
            7, 8:    op = 4'd3;
            default: op = 4'd4;
         endcase
         ins = 16'($urandom);
         ins[15:12] = op;
         do_instr($sformatf("rnd%0d", k), ins, $urandom_range(0, 2), $urandom_range(0, 2),
                  DW'($urandom), lat);
         if (m_halt) do_reset();
      end

      // HALT opcode
      do_reset();
      do_instr("halt", 16'hF000, 0, 0, '0, lat);
      absorb("halt_abs");

      // Undefined opcode 7
      do_reset();
      do_instr("addi_pre_ill", 16'h1105, 0, 0, '0, lat);
      do_instr("ill", 16'h7000, 1, 0, '0, lat);
      check("ill_flag", illegal, 1'b1);
      absorb("ill_abs");

      // Reset during a load's MEM wait
      do_reset();
      mem_ack   = 1'b1;
      mem_rdata = DW'(16'h2604);
      @(posedge Clock); #1;
      mem_ack = 1'b0;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      check("mw_req", mem_req, 1'b1);
      check("mw_we", mem_we, 1'b0);
      check("mw_addr", mem_addr, 16'd4);
      @(posedge Clock); #1;
      check("mw_req_hold", mem_req, 1'b1);
      check("mw_addr_hold", mem_addr, 16'd4);
      Reset   = 1'b1;
      mem_ack = 1'b1;
      #1;
      check("mw_rst_req", mem_req, 1'b0);
      @(posedge Clock); #1;
      Reset   = 1'b0;
      mem_ack = 1'b0;
      #1;
      model_reset();
      check("mw_after_pc", pc, 16'd10);
      check("mw_after_req", mem_req, 1'b1);
      check("mw_after_addr", mem_addr, 16'd10);
      check("mw_after_cnt", retired_cnt, '0);
      check_regs("mw_after");
      do_instr("post_rst_addi", 16'h1105, 0, 0, '0, lat);
      check("post_rst_lat4", lat, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter DATA_W, default 16: register-file, ALU and data-bus width, legal range 16..64.
REQ-002 Parameter NREG, default 4: register count, fixed at 4 by the 2-bit rs/rt/rd fields.
REQ-003 Parameter PC_RESET, default 16'd10: PC value loaded on reset.
REQ-004 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-005 Port Clock, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port Reset, input, 1: synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-007 Port mem_req, output, 1: memory request, held high until acknowledged.
REQ-008 Port mem_we, output, 1: 1 = write, 0 = read; valid while mem_req is high.
REQ-009 Port mem_addr, output, 16: byte address; PC during fetch, ALU result during memory access.
REQ-010 Port mem_wdata, output, DATA_W: store data (rt).
REQ-011 Port mem_rdata, input, DATA_W: read data, valid in the cycle mem_ack is high; fetch uses bits [15:0].
REQ-012 Port mem_ack, input, 1: transfer completes in any cycle where mem_req and mem_ack are both high.
REQ-013 Port pc, output, 16: current PC.
REQ-014 Port halted, output, 1: core stopped by HALT, an illegal opcode, or a trap.
REQ-015 Port illegal, output, 1: sticky flag, set when an undefined opcode is decoded.
REQ-016 Port retire, output, 1: one-cycle pulse when an instruction completes.
REQ-017 Port retired_cnt, output, CNT_W: count of completed instructions; wraps to 0 after overflow.

Function
REQ-018 Instruction encoding: opcode[15:12], rs[11:10], rt[9:8], rd[7:6], funct[1:0], imm[7:0]; imm is sign-extended to DATA_W.
REQ-019 Opcode 0 (R-type): rd = rs op rt, where funct 00 = add, 01 = sub, 10 = and, 11 = or.
REQ-020 Other opcodes: 1 = ADDI (rt = rs + imm); 2 = LW (rt = mem[rs + imm]); 3 = SW (mem[rs + imm] = rt); 4 = BEQ; 15 = HALT; all others are illegal.
REQ-021 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-022 FETCH: mem_req = 1, mem_we = 0, mem_addr = pc; on ack, latch the instruction, set pc = pc + 2, go to DECODE; while ack is low, hold in FETCH with all outputs stable.
REQ-023 DECODE: read rs and rt into operand registers; HALT or illegal opcode -> HALT state, otherwise -> EXEC.
REQ-024 EXEC: compute the ALU result into a result register; R-type/ADDI -> WB; LW/SW -> MEM; BEQ -> FETCH, loading pc = pc + (sext(imm) << 1) when rs == rt.
REQ-025 MEM: issue the request with mem_addr = result[15:0]; on ack, LW latches mem_rdata and goes to WB, SW goes to FETCH.
REQ-026 WB: write the register file, then go to FETCH.
REQ-027 retire pulses for exactly one cycle on the transition into FETCH from WB, MEM(SW) or EXEC(BEQ), and retired_cnt increments in the same edge.
REQ-028 Latency with zero-wait ack: BEQ = 3 cycles, R-type/ADDI/SW = 4 cycles, LW = 5 cycles; each wait cycle adds one cycle.
REQ-029 Arithmetic is modulo 2^DATA_W; the BEQ target is modulo 2^16.
REQ-030 HALT state is absorbing: halted = 1, mem_req = 0, no further register or PC writes; only Reset leaves it.
REQ-031 mem_req deasserts in the cycle after ack; back-to-back requests are permitted only across a state change.

Reset
REQ-032 Reset values: pc = PC_RESET, state = FETCH, all registers = 0, retired_cnt = 0, mem_req = 0 in the reset cycle, halted = 0, illegal = 0, retire = 0.
REQ-033 Reset asserted mid-transaction abandons the transaction; an ack arriving during Reset is ignored.

Configuration
REQ-034 Macro DATAPATH_OVF_TRAP_EN enables the overflow trap.
REQ-035 With the macro defined, signed overflow on add, sub or ADDI suppresses the WB write, sets halted, and moves to HALT without retiring the instruction.
REQ-036 Without the macro, overflow wraps silently.

Structure
REQ-037 Package dp_pkg holds the opcode constants, funct constants and the FSM state enum.
REQ-038 Sub-module dp_alu is combinational: operands, funct select, result, zero and overflow outputs.

Verification
REQ-039 Reset, then ADDI r1, r0, 5 with zero-wait ack -> r1 = 5, retire asserted at cycle 4, pc = 12.
REQ-040 LW with ack delayed 3 cycles -> mem_addr held stable, completes in 8 cycles, rt = mem_rdata.
REQ-041 BEQ with r1 == r2 and imm = -2 at pc = 20 -> pc = 18; with r1 != r2 -> pc = 22.
REQ-042 Opcode 7 -> illegal = 1, halted = 1, mem_req stays 0, retired_cnt unchanged.
REQ-043 Reset asserted during a MEM wait -> state = FETCH, pc = 10 on the next cycle.
REQ-044 With DATAPATH_OVF_TRAP_EN, add 0x7FFF + 1 (DATA_W = 16) -> halted = 1 and rd unchanged; without the macro -> rd = 0x8000.
